// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change one coin at a time, largest first, over a 4-phase req/ack hopper handshake
module change_dispenser #(
  parameter int HI_VALUE = 5,
  parameter int LO_VALUE = 1,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       hi_empty,
  input  logic       lo_empty,
  input  logic       coin_ack,
  input  logic       fault_clr,
  output logic       coin_req,
  output logic       coin_sel,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [7:0] hi_count,
  output logic [7:0] lo_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, REL, DONE, FAULT} state_t;

  state_t        state, next;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          timed_out;
  logic          use_hi, use_lo;
  logic          coin_req_d, coin_sel_d, busy_d, done_d, fault_d;
  logic [7:0]    remaining_d, hi_count_d, lo_count_d;

  assign timed_out = (tcnt == TW'(TIMEOUT - 1));
  // A coin is only eligible when it cannot underflow the owed amount.
  assign use_hi = (remaining >= 8'(HI_VALUE)) && !hi_empty;
  assign use_lo = (remaining >= 8'(LO_VALUE)) && !lo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      coin_req  <= 1'b0;
      coin_sel  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= 8'd0;
      hi_count  <= 8'd0;
      lo_count  <= 8'd0;
    end else begin
      state     <= next;
      tcnt      <= tcnt_d;
      coin_req  <= coin_req_d;
      coin_sel  <= coin_sel_d;
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
      remaining <= remaining_d;
      hi_count  <= hi_count_d;
      lo_count  <= lo_count_d;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:  if (start) next = CHECK;
      CHECK: begin
        if (remaining == 8'd0)  next = DONE;
        else if (use_hi)        next = REQ;
        else if (use_lo)        next = REQ;
        else                    next = FAULT;
      end
      REQ: begin
        if (coin_ack)           next = REL;
        else if (timed_out)     next = FAULT;
      end
      REL: begin
        if (!coin_ack)          next = CHECK;
        else if (timed_out)     next = FAULT;
      end
      DONE:  next = IDLE;
      FAULT: if (fault_clr) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Next values for the registered outputs; flags follow the state being entered.
  always_comb begin
    remaining_d = remaining;
    hi_count_d  = hi_count;
    lo_count_d  = lo_count;
    coin_sel_d  = coin_sel;
    case (state)
      IDLE: begin
        if (start) begin
          remaining_d = amount;
          hi_count_d  = 8'd0;
          lo_count_d  = 8'd0;
        end
      end
      CHECK: begin
        if (remaining != 8'd0) begin
          if (use_hi)      coin_sel_d = 1'b1;
          else if (use_lo) coin_sel_d = 1'b0;
        end
      end
      REQ: begin
        if (coin_ack) begin
          if (coin_sel) begin
            remaining_d = remaining - 8'(HI_VALUE);
            if (hi_count != 8'hff) hi_count_d = hi_count + 8'd1;
          end else begin
            remaining_d = remaining - 8'(LO_VALUE);
            if (lo_count != 8'hff) lo_count_d = lo_count + 8'd1;
          end
        end
      end
      default: ;
    endcase
    coin_req_d = (next == REQ);
    busy_d     = (next != IDLE);
    done_d     = (next == DONE);
    fault_d    = (next == FAULT);
    // The timeout only runs while waiting on the hopper and restarts on every state entry.
    if ((next == state) && ((state == REQ) || (state == REL))) tcnt_d = tcnt + TW'(1);
    else                                                       tcnt_d = '0;
  end

endmodule
